// File: rtl/slot_allocator.sv
// Busy/free tracker for NUM_SLOT slots; offers the lowest-numbered free slot each cycle.
// Optional same-cycle offer of a released slot when full: define SLOT_ALLOCATOR_FREE_BYPASS_EN.
module slot_allocator #(
    parameter int NUM_SLOT = 16,
    localparam int IW = $clog2(NUM_SLOT),
    localparam int CW = $clog2(NUM_SLOT + 1)
) (
    input  logic                clk_i,
    input  logic                arst_i,
    input  logic                flush_i,
    input  logic                alloc_ready_i,
    output logic                alloc_valid_o,
    output logic [IW-1:0]       alloc_idx_o,
    input  logic                free_valid_i,
    input  logic [IW-1:0]       free_idx_i,
    output logic [NUM_SLOT-1:0] busy_o,
    output logic [CW-1:0]       free_count_o,
    output logic                err_o
);

    logic [NUM_SLOT-1:0] busy_q, busy_d;
    logic [CW-1:0]       free_count_q, free_count_d;
    logic                err_q, err_d;

    logic [IW-1:0] lowest_idx;
    logic          any_free;
    logic          in_range;
    logic          free_ok;
    logic          bypass;
    logic          alloc_fire;
    logic          free_fire;
    logic          bad_ready;

    // Scan downward so the last assignment wins with the lowest free index.
    always_comb begin
        lowest_idx = '0;
        for (int i = NUM_SLOT - 1; i >= 0; i--) begin
            if (!busy_q[i]) lowest_idx = IW'(i);
        end
    end

    assign any_free = ~&busy_q;
    assign in_range = ({1'b0, free_idx_i} < (IW + 1)'(NUM_SLOT));
    assign free_ok  = free_valid_i && in_range && busy_q[free_idx_i];

`ifdef SLOT_ALLOCATOR_FREE_BYPASS_EN
    assign bypass    = !any_free && free_ok;
    assign bad_ready = alloc_ready_i && !alloc_valid_o && !free_valid_i;
`else
    assign bypass    = 1'b0;
    assign bad_ready = alloc_ready_i && !alloc_valid_o;
`endif

    assign alloc_valid_o = any_free || bypass;
    assign alloc_idx_o   = bypass ? free_idx_i : lowest_idx;
    assign alloc_fire    = alloc_valid_o && alloc_ready_i;
    assign free_fire     = free_ok;

    // Release clears before allocation sets, so a bypassed slot ends up busy again.
    always_comb begin
        busy_d       = busy_q;
        free_count_d = free_count_q;
        err_d        = err_q;
        if (flush_i) begin
            busy_d       = '0;
            free_count_d = CW'(NUM_SLOT);
        end else begin
            if (free_fire)  busy_d[free_idx_i]  = 1'b0;
            if (alloc_fire) busy_d[alloc_idx_o] = 1'b1;
            free_count_d = free_count_q + CW'(free_fire) - CW'(alloc_fire);
            if ((free_valid_i && !free_ok) || bad_ready) err_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            busy_q       <= '0;
            free_count_q <= CW'(NUM_SLOT);
            err_q        <= 1'b0;
        end else begin
            busy_q       <= busy_d;
            free_count_q <= free_count_d;
            err_q        <= err_d;
        end
    end

    assign busy_o       = busy_q;
    assign free_count_o = free_count_q;
    assign err_o        = err_q;

endmodule

// File: tb/tb_slot_allocator.sv
// Directed and model-checked random bench for slot_allocator (16-slot and 20-slot instances).
module tb_slot_allocator;

    logic        clk = 1'b0;
    logic        arst;
    logic        flush, ready, fvalid;
    logic [3:0]  fidx;
    logic        avalid;
    logic [3:0]  aidx;
    logic [15:0] busy;
    logic [4:0]  count;
    logic        err;

    logic        flush20, ready20, fvalid20;
    logic [4:0]  fidx20;
    logic        avalid20;
    logic [4:0]  aidx20;
    logic [19:0] busy20;
    logic [4:0]  count20;
    logic        err20;

    int tests_run = 0;
    int fails = 0;

    always #5 clk = ~clk;

    slot_allocator #(.NUM_SLOT(16)) dut (
        .clk_i(clk), .arst_i(arst), .flush_i(flush), .alloc_ready_i(ready),
        .alloc_valid_o(avalid), .alloc_idx_o(aidx), .free_valid_i(fvalid),
        .free_idx_i(fidx), .busy_o(busy), .free_count_o(count), .err_o(err)
    );

    slot_allocator #(.NUM_SLOT(20)) dut20 (
        .clk_i(clk), .arst_i(arst), .flush_i(flush20), .alloc_ready_i(ready20),
        .alloc_valid_o(avalid20), .alloc_idx_o(aidx20), .free_valid_i(fvalid20),
        .free_idx_i(fidx20), .busy_o(busy20), .free_count_o(count20), .err_o(err20)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        flush = 0; ready = 0; fvalid = 0; fidx = 0;
        flush20 = 0; ready20 = 0; fvalid20 = 0; fidx20 = 0;
        arst = 1;
        #3;
        arst = 0;
        tick();
    endtask

    task automatic test_reset();
        do_reset();
        tests_run++;
        if (busy !== 16'h0 || count !== 5'd16 || avalid !== 1'b1 || aidx !== 4'd0 || err !== 1'b0) begin
            fails++;
            $display("FAIL reset: busy=%h count=%0d valid=%b idx=%0d err=%b, want 0000/16/1/0/0",
                     busy, count, avalid, aidx, err);
        end
    endtask

    task automatic test_fill();
        do_reset();
        ready = 1;
        for (int i = 0; i < 16; i++) begin
            #1;
            tests_run++;
            if (avalid !== 1'b1 || aidx !== 4'(i)) begin
                fails++;
                $display("FAIL fill_offer: valid=%b idx=%0d, want 1/%0d", avalid, aidx, i);
            end
            tick();
        end
        ready = 0;
        #1;
        tests_run++;
        if (avalid !== 1'b0 || aidx !== 4'd0 || count !== 5'd0 || busy !== 16'hFFFF) begin
            fails++;
            $display("FAIL fill_full: valid=%b idx=%0d count=%0d busy=%h, want 0/0/0/ffff",
                     avalid, aidx, count, busy);
        end
    endtask

    // Continues from the full state left by test_fill.
    task automatic test_release_from_full();
        fvalid = 1; fidx = 4'd5;
        #1;
        tests_run++;
`ifdef SLOT_ALLOCATOR_FREE_BYPASS_EN
        if (avalid !== 1'b1 || aidx !== 4'd5) begin
            fails++;
            $display("FAIL bypass_offer: valid=%b idx=%0d, want 1/5", avalid, aidx);
        end
        ready = 1;
        tick();
        ready = 0; fvalid = 0;
        #1;
        tests_run++;
        if (busy !== 16'hFFFF || count !== 5'd0) begin
            fails++;
            $display("FAIL bypass_accept: busy=%h count=%0d, want ffff/0", busy, count);
        end
`else
        if (avalid !== 1'b0) begin
            fails++;
            $display("FAIL release_same_cycle: valid=%b, want 0", avalid);
        end
        tick();
        fvalid = 0;
        #1;
        tests_run++;
        if (avalid !== 1'b1 || aidx !== 4'd5 || count !== 5'd1 || busy !== 16'hFFDF) begin
            fails++;
            $display("FAIL release_next: valid=%b idx=%0d count=%0d busy=%h, want 1/5/1/ffdf",
                     avalid, aidx, count, busy);
        end
`endif
    endtask

    task automatic test_same_cycle();
        do_reset();
        ready = 1;
        repeat (4) tick();
        fvalid = 1; fidx = 4'd2;
        #1;
        tests_run++;
        if (aidx !== 4'd4) begin
            fails++;
            $display("FAIL same_cycle_offer: idx=%0d, want 4", aidx);
        end
        tick();
        ready = 0; fvalid = 0;
        #1;
        tests_run++;
        if (busy !== 16'h001B || count !== 5'd12 || aidx !== 4'd2) begin
            fails++;
            $display("FAIL same_cycle: busy=%h count=%0d idx=%0d, want 001b/12/2", busy, count, aidx);
        end
    endtask

    task automatic test_errors();
        do_reset();
        fvalid = 1; fidx = 4'd7;
        tick();
        fvalid = 0;
        #1;
        tests_run++;
        if (err !== 1'b1 || busy !== 16'h0 || count !== 5'd16) begin
            fails++;
            $display("FAIL double_free: err=%b busy=%h count=%0d, want 1/0000/16", err, busy, count);
        end
        repeat (3) tick();
        tests_run++;
        if (err !== 1'b1) begin
            fails++;
            $display("FAIL err_sticky: err=%b, want 1", err);
        end
        tests_run++;
        if (err20 !== 1'b0) begin
            fails++;
            $display("FAIL range_pre: err=%b, want 0", err20);
        end
        fvalid20 = 1; fidx20 = 5'd20;
        tick();
        fvalid20 = 0;
        #1;
        tests_run++;
        if (err20 !== 1'b1 || busy20 !== 20'h0 || count20 !== 5'd20) begin
            fails++;
            $display("FAIL out_of_range: err=%b busy=%h count=%0d, want 1/00000/20", err20, busy20, count20);
        end
    endtask

    task automatic test_flush();
        do_reset();
        ready = 1;
        repeat (10) tick();
        ready = 0;
        fvalid = 1; fidx = 4'd12;
        tick();
        fvalid = 0;
        #1;
        tests_run++;
        if (busy !== 16'h03FF || count !== 5'd6 || err !== 1'b1) begin
            fails++;
            $display("FAIL flush_pre: busy=%h count=%0d err=%b, want 03ff/6/1", busy, count, err);
        end
        flush = 1; ready = 1;
        tick();
        flush = 0; ready = 0;
        #1;
        tests_run++;
        if (busy !== 16'h0 || count !== 5'd16 || aidx !== 4'd0 || err !== 1'b1) begin
            fails++;
            $display("FAIL flush: busy=%h count=%0d idx=%0d err=%b, want 0000/16/0/1", busy, count, aidx, err);
        end
    endtask

    task automatic test_random();
        logic [15:0] bm;
        logic        em;
        logic        vm;
        logic [3:0]  im;
        logic [4:0]  cm;
        do_reset();
        bm = '0; em = 0;
        for (int c = 0; c < 1000; c++) begin
            ready  = ($urandom_range(0, 3) != 0);
            fvalid = ($urandom_range(0, 2) == 0);
            fidx   = 4'($urandom_range(0, 15));
            flush  = ($urandom_range(0, 63) == 0);
            vm = (bm != 16'hFFFF);
            im = 4'd0;
            for (int i = 15; i >= 0; i--) if (!bm[i]) im = 4'(i);
`ifdef SLOT_ALLOCATOR_FREE_BYPASS_EN
            if (!vm && fvalid && bm[fidx]) begin
                vm = 1; im = fidx;
            end
`endif
            #1;
            tests_run++;
            if (avalid !== vm || aidx !== im) begin
                fails++;
                $display("FAIL rand_offer c=%0d: valid=%b idx=%0d, want %b/%0d", c, avalid, aidx, vm, im);
            end
            if (!flush) begin
                if (fvalid && !bm[fidx]) em = 1;
`ifdef SLOT_ALLOCATOR_FREE_BYPASS_EN
                if (ready && !vm && !fvalid) em = 1;
`else
                if (ready && !vm) em = 1;
`endif
                if (fvalid) bm[fidx] = 1'b0;
                if (ready && vm) bm[im] = 1'b1;
            end else begin
                bm = '0;
            end
            tick();
            cm = 0;
            for (int i = 0; i < 16; i++) cm += 5'(!bm[i]);
            tests_run++;
            if (busy !== bm || count !== cm || err !== em) begin
                fails++;
                $display("FAIL rand_state c=%0d: busy=%h count=%0d err=%b, want %h/%0d/%b",
                         c, busy, count, err, bm, cm, em);
            end
            if (c == 500) begin
                arst = 1;
                #1;
                tests_run++;
                if (busy !== 16'h0 || count !== 5'd16 || avalid !== 1'b1 || aidx !== 4'd0 || err !== 1'b0) begin
                    fails++;
                    $display("FAIL mid_reset: busy=%h count=%0d valid=%b idx=%0d err=%b",
                             busy, count, avalid, aidx, err);
                end
                arst = 0;
                bm = '0; em = 0;
            end
        end
        ready = 0; fvalid = 0; flush = 0;
    endtask

    initial begin
        test_reset();
        test_fill();
        test_release_from_full();
        test_same_cycle();
        test_errors();
        test_flush();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
